queue_p: RTL and testbench
==========================

# queue_p

Parametrised synchronous FIFO: the next-generation acquisition-path queue, generalised in data width and depth. Adds full, almost-full and almost-empty flags, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. Sits between the sampling front-end (producer, `ld`) and the transfer/packetiser logic (consumer, `pp`). Output is first-word-fall-through: the head entry is always visible on `out`.

## Interface
- `WIDTH`, 8, data word width in bits (≥1).
- `DEPTH`, 16, number of entries; power of two, ≥2.
- `AF_LEVEL`, DEPTH-2, `af` asserts when `cnt` ≥ AF_LEVEL.
- `AE_LEVEL`, 2, `ae` asserts when `cnt` ≤ AE_LEVEL.
- `ck`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in`  in  WIDTH  write data, sampled when a push is accepted.
- `ld`  in  1  push request.
- `pp`  in  1  pop request.
- `clr`  in  1  synchronous flush, active-high.
- `out`  out  WIDTH  head-of-queue data (FWFT).
- `em`  out  1  empty.
- `fu`  out  1  full.
- `ae`  out  1  almost empty.
- `af`  out  1  almost full.
- `cnt`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `ovf`  out  1  sticky: push attempted while full without a pop in the same cycle.
- `udf`  out  1  sticky: pop attempted while empty.

## Operation
- Reset (`rst_n`=0 at edge): pointers=0, `cnt`=0, `em`=1, `fu`=0, `ae`=1, `af`=0, `ovf`=0, `udf`=0, `out`=0. Memory contents are not cleared.
- Priority at each edge: `rst_n` > `clr` > `ld`/`pp`.
- `clr`: same effect as reset on pointers, `cnt`, flags, `ovf` and `udf`; `ld`/`pp` in that cycle are ignored.
- Push accepted if `ld` and (not `fu` or `pp`): write `in` at wr_ptr; wr_ptr+1 mod DEPTH.
- Pop accepted if `pp` and not `em`: rd_ptr+1 mod DEPTH.
- `ld`&`pp` when empty: push only; `udf` sets; `cnt` becomes 1.
- `ld`&`pp` when full: both accepted; `cnt` stays DEPTH; `ovf` is not set.
- `ld`&`pp` otherwise: both accepted; `cnt` unchanged.
- `ld` when full without `pp`: write dropped, queue contents intact, `ovf` sets.
- `pp` when empty without `ld`: no pointer change, `udf` sets.
- Pointers carry one extra wrap bit: `em` = (wr_ptr==rd_ptr); `fu` = low bits equal and wrap bits differ. `cnt` = wr_ptr − rd_ptr, computed in ptr width (modular).
- `out` = mem[rd_ptr] when not `em`, else 0. Never X after reset.
- `ovf`/`udf` clear only on reset or `clr`.

## Timing
- All flags, `cnt` and `out` are combinational from registered state, so they update in the cycle after the accepting edge.
- Push-to-out latency on an empty FIFO: 1 cycle. Data written at edge N appears on `out` after edge N with `em`=0.
- Pop: `out` advances to the next entry right after the popping edge.
- Throughput: one push and one pop per cycle, sustained.
- Wrap-around: after DEPTH pushes and DEPTH pops, pointer low bits return to 0 and order is preserved.

## Structure
- Shared package/header `queue_pkg`: pointer-width function (clog2), default WIDTH/DEPTH constants.
- Sub-module `queue_ram`: DEPTH×WIDTH register file, one synchronous write port and one asynchronous read port.
- Top level holds pointers, flag logic and the sticky error flags.

## Test plan
- Reset, then push 0x10, 0x09, 0x0A (WIDTH=8, DEPTH=4), then pop ×3 -> `out` shows 0x10, 0x09, 0x0A in order; `em`=1 after the third pop; `cnt` goes 3→0.
- Push 4 words into DEPTH=4 -> `fu`=1, `af`=1 at `cnt`≥2; fifth push without `pp` -> `ovf`=1 and contents unchanged.
- Pop on empty -> `udf`=1, `cnt`=0. `ld`&`pp` on empty with 0x55 -> `cnt`=1, `out`=0x55.
- Fill, then `ld`&`pp` for 8 cycles with an incrementing pattern -> `cnt` stays 4, no `ovf`, output order matches input (covers wrap-around).
- Load 3 words, assert `clr` together with `ld` -> `cnt`=0, `em`=1, `ovf`/`udf` cleared, pushed word discarded.
- Assert `rst_n`=0 mid-stream with `cnt`=2 -> the next cycle shows all outputs at their reset values.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared definitions for the acquisition-path queue: default geometry and
// the pointer-width helper used by the top level and the storage array.
package queue_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  // Address bits needed to index a DEPTH-entry array (DEPTH is a power of two)
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/queue_ram.sv
// DEPTH x WIDTH register file for the queue.
// Ports: ck (clock), we/waddr/wdata (synchronous write port),
//        raddr/rdata (asynchronous read port).
// Contents are deliberately not reset; the top level masks reads when empty.
module queue_ram
  import queue_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW   = ptr_w(DEPTH)
) (
  input  logic             ck,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port
  always_ff @(posedge ck) begin
    if (we) mem[waddr] <= wdata;
  end

  // Combinational read gives first-word-fall-through at the top level
  assign rdata = mem[raddr];

endmodule

// File: rtl/queue_p.sv
// Parametrised first-word-fall-through FIFO between the sampling front-end
// (producer, ld) and the packetiser (consumer, pp).
// Ports: ck, rst_n (sync, active-low), in/ld (push), pp (pop), clr (flush);
//        out (head data, 0 when empty), em/fu/ae/af (status flags),
//        cnt (occupancy 0..DEPTH), ovf/udf (sticky error flags).
module queue_p
  import queue_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned AW      = ptr_w(DEPTH),
  localparam int unsigned CW      = AW + 1
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             ld,
  input  logic             pp,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             em,
  output logic             fu,
  output logic             ae,
  output logic             af,
  output logic [CW-1:0]    cnt,
  output logic             ovf,
  output logic             udf
);

  // Pointers carry one wrap bit above the address bits
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic             ovf_q;
  logic             udf_q;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rdata;

  assign em  = (wr_ptr == rd_ptr);
  assign fu  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign cnt = wr_ptr - rd_ptr;
  assign ae  = (32'(cnt) <= AE_LEVEL);
  assign af  = (32'(cnt) >= AF_LEVEL);

  // A pop frees the slot in the same cycle, so a full queue can still accept
  assign push = ld && (!fu || pp);
  assign pop  = pp && !em;

  // Pointer and sticky error state; reset beats flush beats push/pop
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (push)             wr_ptr <= wr_ptr + CW'(1);
      if (pop)              rd_ptr <= rd_ptr + CW'(1);
      if (ld && fu && !pp)  ovf_q  <= 1'b1;
      if (pp && em)         udf_q  <= 1'b1;
    end
  end

  queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .ck    (ck),
    .we    (rst_n && !clr && push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  // Mask the unreset storage so out is never X while empty
  assign out = em ? '0 : rdata;
  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule

// File: tb/tb_queue_p.sv
// Bench for queue_p (WIDTH=8, DEPTH=4): directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_queue_p;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic          ck = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in = '0;
  logic          ld = 1'b0;
  logic          pp = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  out;
  logic          em, fu, ae, af, ovf, udf;
  logic [CW-1:0] cnt;

  queue_p #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (2),
    .AE_LEVEL (1)
  ) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .in    (in),
    .ld    (ld),
    .pp    (pp),
    .clr   (clr),
    .out   (out),
    .em    (em),
    .fu    (fu),
    .ae    (ae),
    .af    (af),
    .cnt   (cnt),
    .ovf   (ovf),
    .udf   (udf)
  );

  always #5 ck = ~ck;

  // Reference model: full contents (mq) and the data scoreboard (sb_q)
  logic [W-1:0] mq[$];
  logic [W-1:0] sb_q[$];
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;
  bit           mon_en = 1'b0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit l, input bit p, input bit c, input bit r,
                            input logic [W-1:0] d);
    bit full, empty;
    if (!r || c) begin
      mq.delete();
      sb_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      full  = (mq.size() == D);
      empty = (mq.size() == 0);
      if (p && empty)        m_udf = 1'b1;
      if (l && full && !p)   m_ovf = 1'b1;
      if (p && !empty)       void'(mq.pop_front());
      if (l && (!full || p)) begin
        mq.push_back(d);
        sb_q.push_back(d);
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model
  task automatic cyc(input bit l, input bit p, input bit c, input bit r,
                     input logic [W-1:0] d);
    ld = l; pp = p; clr = c; rst_n = r; in = d;
    @(posedge ck);
    model_step(l, p, c, r, d);
    #1;
  endtask

  // Monitor: compares DUT status against the model, and on every pop the DUT
  // is about to take, the head word against the scoreboard
  always @(negedge ck) begin
    if (mon_en) begin
      chk("cnt", 32'(cnt), 32'(mq.size()));
      chk("em",  32'(em),  32'(mq.size() == 0));
      chk("fu",  32'(fu),  32'(mq.size() == D));
      chk("ae",  32'(ae),  32'(mq.size() <= 1));
      chk("af",  32'(af),  32'(mq.size() >= 2));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("udf", 32'(udf), 32'(m_udf));
      chk("out", 32'(out), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      if (rst_n && !clr && pp && !em) begin
        if (sb_q.size() == 0) begin
          chk("pop_on_empty_scoreboard", 32'(em), 32'd1);
        end else begin
          chk("pop_data", 32'(out), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 8'h00);
    mon_en = 1'b1;
    cyc(0, 0, 0, 0, 8'h00);

    // Ordered push then pop
    cyc(1, 0, 0, 1, 8'h10);
    cyc(1, 0, 0, 1, 8'h09);
    cyc(1, 0, 0, 1, 8'h0A);
    repeat (3) cyc(0, 1, 0, 1, 8'h00);

    // Fill, then overflow attempt
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 8'hA0 + 8'(i));
    // Simultaneous push/pop at full across wrap
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 1, 8'h30 + 8'(i));
    repeat (4) cyc(0, 1, 0, 1, 8'h00);

    // Underflow, then push+pop on empty
    cyc(0, 1, 0, 1, 8'h00);
    cyc(1, 1, 0, 1, 8'h55);
    cyc(0, 1, 0, 1, 8'h00);

    // Flush wins over a push
    cyc(1, 0, 0, 1, 8'h01);
    cyc(1, 0, 0, 1, 8'h02);
    cyc(1, 0, 0, 1, 8'h03);
    cyc(1, 0, 1, 1, 8'h04);

    // Reset mid-stream
    cyc(1, 0, 0, 1, 8'h11);
    cyc(1, 0, 0, 1, 8'h22);
    cyc(1, 1, 0, 0, 8'h33);
    cyc(0, 0, 0, 1, 8'h00);

    // Randomized traffic with shifting push/pop bias
    for (int ph = 0; ph < 6; ph++) begin
      int unsigned pl, pq;
      pl = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
      pq = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 55;
      for (int i = 0; i < 300; i++) begin
        bit l, p, c, r;
        l = ($urandom_range(99) < pl);
        p = ($urandom_range(99) < pq);
        c = ($urandom_range(63) == 0);
        r = ($urandom_range(199) != 0);
        cyc(l, p, c, r, 8'($urandom));
      end
    end

    cyc(0, 0, 0, 1, 8'h00);
    @(negedge ck);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
